// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALU operation codes, RV32I opcode/funct fields,
// and the operand-select types produced by the decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {XSelZero, XSelRs1, XSelPc} x_sel_e;
    typedef enum logic [1:0] {YSelImm, YSelRs2, YSelShamt} y_sel_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I ALU-class decoder: operation code, operand selects, immediate,
// legality and destination write enable. Illegal encodings decode to ADD 0 + 0.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_ctrl_o,
    output x_sel_e      x_sel_o,
    output y_sel_e      y_sel_o,
    output logic [31:0] imm_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o,
    output logic        legal_o,
    output logic        rd_we_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i_type;
    logic [31:0] imm_u_type;
    logic [31:0] imm_shamt;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign rd         = instr_i[11:7];
    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u_type = {instr_i[31:12], 12'b0};
    assign imm_shamt  = {27'b0, instr_i[24:20]};

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        x_sel_o    = XSelZero;
        y_sel_o    = YSelImm;
        imm_o      = 32'b0;
        use_rs1_o  = 1'b0;
        use_rs2_o  = 1'b0;
        legal_o    = 1'b0;

        case (opcode)
            OPC_OP: begin
                use_rs1_o = 1'b1;
                use_rs2_o = 1'b1;
                x_sel_o   = XSelRs1;
                y_sel_o   = YSelRs2;
                legal_o   = (funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
                case (funct3)
                    F3_ADD_SUB: alu_ctrl_o = funct7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL: begin
                        alu_ctrl_o = ALU_SLL;
                        y_sel_o    = YSelShamt;
                    end
                    F3_SLT:  alu_ctrl_o = ALU_SLT;
                    F3_SLTU: alu_ctrl_o = ALU_SLTU;
                    F3_XOR:  alu_ctrl_o = ALU_XOR;
                    F3_SR: begin
                        alu_ctrl_o = funct7[5] ? ALU_SRA : ALU_SRL;
                        y_sel_o    = YSelShamt;
                    end
                    F3_OR:   alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1_o = 1'b1;
                x_sel_o   = XSelRs1;
                imm_o     = imm_i_type;
                legal_o   = 1'b1;
                case (funct3)
                    F3_ADD_SUB: alu_ctrl_o = ALU_ADD;
                    F3_SLL: begin
                        alu_ctrl_o = ALU_SLL;
                        imm_o      = imm_shamt;
                        legal_o    = (funct7 == F7_BASE);
                    end
                    F3_SLT:  alu_ctrl_o = ALU_SLT;
                    F3_SLTU: alu_ctrl_o = ALU_SLTU;
                    F3_XOR:  alu_ctrl_o = ALU_XOR;
                    F3_SR: begin
                        alu_ctrl_o = funct7[5] ? ALU_SRA : ALU_SRL;
                        imm_o      = imm_shamt;
                        legal_o    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    F3_OR:   alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                alu_ctrl_o = ALU_LUI;
                imm_o      = imm_u_type;
                legal_o    = 1'b1;
            end
            OPC_AUIPC: begin
                x_sel_o = XSelPc;
                imm_o   = imm_u_type;
                legal_o = 1'b1;
            end
            default: ;
        endcase

        // Illegal instructions still flow downstream, but as a harmless ADD 0 + 0.
        if (!legal_o) begin
            alu_ctrl_o = ALU_ADD;
            x_sel_o    = XSelZero;
            y_sel_o    = YSelImm;
            imm_o      = 32'b0;
            use_rs1_o  = 1'b0;
            use_rs2_o  = 1'b0;
        end
    end

    assign rd_we_o = legal_o && (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU: decodes, forwards operands from EX/WB and holds
// one instruction in a valid/ready pipeline register with flush.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter logic [31:0] RESET_PC_FIELD = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] data_x,
    output logic [XLEN-1:0] data_y,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic [31:0]     out_pc,
    output logic            out_illegal
);

    logic [3:0]      dec_ctrl;
    x_sel_e          dec_x_sel;
    y_sel_e          dec_y_sel;
    logic [31:0]     dec_imm;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic            dec_legal;
    logic            dec_rd_we;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_x;
    logic [XLEN-1:0] op_y;
    logic            accept;

    logic            valid_q, valid_d;
    logic            rd_we_q, rd_we_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0] data_x_q, data_x_d;
    logic [XLEN-1:0] data_y_q, data_y_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     pc_q, pc_d;

    alu_decoder u_alu_decoder (
        .instr_i    (in_instr),
        .alu_ctrl_o (dec_ctrl),
        .x_sel_o    (dec_x_sel),
        .y_sel_o    (dec_y_sel),
        .imm_o      (dec_imm),
        .use_rs1_o  (dec_use_rs1),
        .use_rs2_o  (dec_use_rs2),
        .legal_o    (dec_legal),
        .rd_we_o    (dec_rd_we)
    );

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // EX result outranks WB because it is the younger producer; x0 always reads as zero.
    always_comb begin
        rs1_val = rs1_data;
        if (!dec_use_rs1 || rs1_addr == 5'd0) begin
            rs1_val = '0;
        end else if (valid_q && rd_we_q && rd_q == rs1_addr) begin
            rs1_val = alu_result;
        end else if (wb_we && wb_rd == rs1_addr) begin
            rs1_val = wb_data;
        end

        rs2_val = rs2_data;
        if (!dec_use_rs2 || rs2_addr == 5'd0) begin
            rs2_val = '0;
        end else if (valid_q && rd_we_q && rd_q == rs2_addr) begin
            rs2_val = alu_result;
        end else if (wb_we && wb_rd == rs2_addr) begin
            rs2_val = wb_data;
        end
    end

    always_comb begin
        unique case (dec_x_sel)
            XSelRs1: op_x = rs1_val;
            XSelPc:  op_x = in_pc;
            default: op_x = '0;
        endcase

        // The ALU shifts by all of data_y, so register shift amounts are masked to 5 bits.
        unique case (dec_y_sel)
            YSelRs2:   op_y = rs2_val;
            YSelShamt: op_y = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
            default:   op_y = dec_imm;
        endcase
    end

    assign in_ready = !rst && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d    = valid_q;
        rd_we_d    = rd_we_q;
        illegal_d  = illegal_q;
        alu_ctrl_d = alu_ctrl_q;
        data_x_d   = data_x_q;
        data_y_d   = data_y_q;
        rd_d       = rd_q;
        pc_d       = pc_q;

        if (flush) begin
            valid_d   = 1'b0;
            rd_we_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            rd_we_d    = dec_rd_we;
            illegal_d  = !dec_legal;
            alu_ctrl_d = dec_ctrl;
            data_x_d   = op_x;
            data_y_d   = op_y;
            rd_d       = in_instr[11:7];
            pc_d       = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
            alu_ctrl_q <= ALU_ADD;
            data_x_q   <= '0;
            data_y_q   <= '0;
            rd_q       <= 5'd0;
            pc_q       <= RESET_PC_FIELD;
        end else begin
            valid_q    <= valid_d;
            rd_we_q    <= rd_we_d;
            illegal_q  <= illegal_d;
            alu_ctrl_q <= alu_ctrl_d;
            data_x_q   <= data_x_d;
            data_y_q   <= data_y_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_rd_we   = rd_we_q;
    assign out_illegal = illegal_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign data_x      = data_x_q;
    assign data_y      = data_y_q;
    assign out_rd      = rd_q;
    assign out_pc      = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected issue results are queued when an instruction
// is driven and popped when the stage presents it.
module tb_alu_issue_stage;

    localparam logic [31:0] RstPc = 32'hCAFE_0000;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        rd_we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_result;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] data_x;
    logic [31:0] data_y;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_pc;
    logic        out_illegal;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_issue_stage #(
        .XLEN           (32),
        .RESET_PC_FIELD (RstPc)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_result  (alu_result),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .data_x      (data_x),
        .data_y      (data_y),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic exp_t mk(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] rd, input logic we, input logic ill);
        exp_t e;
        e.ctrl  = c;
        e.x     = x;
        e.y     = y;
        e.rd    = rd;
        e.rd_we = we;
        e.ill   = ill;
        e.pc    = 32'h0;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input exp_t e);
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        e.pc     = pc;
        q.push_back(e);
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        cmp({tag, "_sb_depth"}, 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
            cmp({tag, "_ctrl"}, {28'b0, alu_ctrl}, {28'b0, e.ctrl});
            cmp({tag, "_x"}, data_x, e.x);
            cmp({tag, "_y"}, data_y, e.y);
            cmp({tag, "_rd"}, {27'b0, out_rd}, {27'b0, e.rd});
            cmp({tag, "_rd_we"}, {31'b0, out_rd_we}, {31'b0, e.rd_we});
            cmp({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, e.ill});
            cmp({tag, "_pc"}, out_pc, e.pc);
        end
    endtask

    // Drive one instruction, let it load on the next edge, then check and release the input.
    task automatic run_one(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        issue(instr, pc, r1, r2, e);
        step();
        in_valid = 1'b0;
        check_head(tag);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = 32'h0;
        in_pc      = 32'h0;
        rs1_data   = 32'h0;
        rs2_data   = 32'h0;
        alu_result = 32'h0;
        wb_we      = 1'b0;
        wb_rd      = 5'd0;
        wb_data    = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b1;

        step();
        step();
        cmp("rst_valid", {31'b0, out_valid}, 32'd0);
        cmp("rst_in_ready", {31'b0, in_ready}, 32'd0);
        cmp("rst_pc", out_pc, RstPc);
        cmp("rst_ctrl", {28'b0, alu_ctrl}, 32'd0);
        cmp("rst_x", data_x, 32'd0);
        cmp("rst_y", data_y, 32'd0);
        cmp("rst_rd", {27'b0, out_rd}, 32'd0);
        cmp("rst_rd_we", {31'b0, out_rd_we}, 32'd0);
        cmp("rst_ill", {31'b0, out_illegal}, 32'd0);
        rst = 1'b0;
        #1;
        cmp("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD x3,x1,x2
        issue(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h100, 32'd5, 32'd7,
              mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        #1;
        cmp("rs1_addr", {27'b0, rs1_addr}, 32'd1);
        cmp("rs2_addr", {27'b0, rs2_addr}, 32'd2);
        step();
        in_valid = 1'b0;
        check_head("add");

        // Register shifts use only the low five bits of rs2.
        run_one("sra", enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd4), 32'h104, 32'h8000_0000,
                32'h0000_0123, mk(4'd7, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 1'b0));
        run_one("sll", enc_r(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd9), 32'h108, 32'h1,
                32'hFFFF_FFE5, mk(4'd2, 32'h1, 32'd5, 5'd9, 1'b1, 1'b0));
        run_one("srai", enc_i({7'b0100000, 5'd31}, 5'd1, 3'b101, 5'd4), 32'h10C, 32'h1234,
                32'h0, mk(4'd7, 32'h1234, 32'd31, 5'd4, 1'b1, 1'b0));

        // x0 reads as zero even with nonzero register data.
        run_one("addi_x0src", enc_i(12'd10, 5'd0, 3'b000, 5'd5), 32'h110, 32'd77, 32'd0,
                mk(4'd0, 32'd0, 32'd10, 5'd5, 1'b1, 1'b0));

        // EX forwarding beats WB for the same register.
        alu_result = 32'd10;
        wb_we      = 1'b1;
        wb_rd      = 5'd5;
        wb_data    = 32'd99;
        run_one("fwd_ex", enc_i(12'd1, 5'd5, 3'b000, 5'd6), 32'h114, 32'd0, 32'd0,
                mk(4'd0, 32'd10, 32'd1, 5'd6, 1'b1, 1'b0));
        run_one("fwd_wb", enc_r(7'b0000000, 5'd9, 5'd5, 3'b000, 5'd8), 32'h118, 32'd0, 32'd4,
                mk(4'd0, 32'd99, 32'd4, 5'd8, 1'b1, 1'b0));
        wb_we = 1'b0;

        // Downstream stall: held outputs stay put, the waiting instruction is not taken.
        out_ready = 1'b0;
        in_instr  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd9);
        in_pc     = 32'h11C;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("stall_in_ready", {31'b0, in_ready}, 32'd0);
            step();
            cmp("stall_valid", {31'b0, out_valid}, 32'd1);
            cmp("stall_y", data_y, 32'd4);
            cmp("stall_rd", {27'b0, out_rd}, 32'd8);
        end
        out_ready = 1'b1;
        #1;
        cmp("unstall_in_ready", {31'b0, in_ready}, 32'd1);
        issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd9), 32'h11C, 32'd0, 32'd0,
              mk(4'd0, 32'd0, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0));
        step();
        in_valid = 1'b0;
        check_head("after_stall");
        step();
        cmp("no_dup_valid", {31'b0, out_valid}, 32'd0);

        // Illegal encodings and corner decodes.
        run_one("branch", 32'h0020_8463, 32'h120, 32'd1, 32'd2,
                mk(4'd0, 32'd0, 32'd0, 5'd8, 1'b0, 1'b1));
        run_one("add_bad_f7", enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3), 32'h124, 32'd1,
                32'd2, mk(4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        run_one("slli_bad", enc_i({7'b0100000, 5'd3}, 5'd1, 3'b001, 5'd3), 32'h128, 32'd1,
                32'd2, mk(4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        run_one("lui", enc_u(20'hABCDE, 5'd7, 7'b0110111), 32'h12C, 32'd1, 32'd2,
                mk(4'd10, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0));
        run_one("auipc", enc_u(20'h00001, 5'd1, 7'b0010111), 32'h200, 32'd3, 32'd3,
                mk(4'd0, 32'h200, 32'h1000, 5'd1, 1'b1, 1'b0));
        alu_result = 32'hDEAD_0000;
        run_one("addi_rd0", enc_i(12'd1, 5'd1, 3'b000, 5'd0), 32'h204, 32'd3, 32'd0,
                mk(4'd0, 32'hDEAD_0000, 32'd1, 5'd0, 1'b0, 1'b0));

        // Flush with a held instruction and a pending input.
        run_one("pre_flush", enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h208, 32'd5,
                32'd7, mk(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = enc_i(12'd2, 5'd0, 3'b000, 5'd10);
        #1;
        cmp("flush_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        cmp("flush_valid", {31'b0, out_valid}, 32'd0);
        cmp("flush_rd_we", {31'b0, out_rd_we}, 32'd0);
        cmp("flush_ill", {31'b0, out_illegal}, 32'd0);
        step();
        cmp("flush_not_taken", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b1;
        run_one("pre_rst", enc_i(12'd3, 5'd0, 3'b000, 5'd11), 32'h20C, 32'd0, 32'd0,
                mk(4'd0, 32'd0, 32'd3, 5'd11, 1'b1, 1'b0));
        out_ready = 1'b0;
        step();
        cmp("held_before_rst", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst_valid", {31'b0, out_valid}, 32'd0);
        cmp("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
        cmp("async_rst_pc", out_pc, RstPc);
        cmp("async_rst_y", data_y, 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        cmp("sb_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
